closest_hit_tracker: RTL
========================

Name: closest_hit_tracker

Overview:
- Consumes the stream of fp32 ray-parameter values `t`, one per primitive, produced by the intersection datapath built on the vec3 dot-product stage.
- Reduces each ray's candidates to the single nearest valid hit.
- Emits one hit record per ray to shading.
- Fully streaming: accepts one candidate per cycle, no backpressure, matching the valid-only handshake of the upstream arithmetic pipeline.

Parameters:
- PRIM_ID_W, 16, width of primitive index carried with each candidate.
- T_MIN, 32'h3A83126F (0.001f), fp32 bit pattern; candidates with `t <= T_MIN` are rejected (self-intersection epsilon).
- MAX_PRIMS, 1024, max candidates per ray before overflow is flagged.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- t_vld  in  1  candidate valid
- t  in  32  candidate distance, fp32_t
- t_prim_id  in  PRIM_ID_W  primitive index of candidate
- t_last  in  1  candidate is the ray's final one; qualified by t_vld
- hit_vld  out  1  one-cycle pulse, result record valid
- hit  out  1  ray hit something
- hit_t  out  32  nearest `t`; FP32_POS_INF when hit=0
- hit_prim_id  out  PRIM_ID_W  primitive of nearest hit; 0 when hit=0
- overflow  out  1  sticky; MAX_PRIMS exceeded within one ray

Behaviour:
- Reset (asynchronous, rst_n low):
  - hit_vld=0, hit=0, hit_t=FP32_POS_INF, hit_prim_id=0, overflow=0.
  - Internal state to EMPTY, best cleared, candidate count 0.
  - Reset mid-ray discards the partial ray; no result is emitted for it.
- Candidate acceptance:
  - Candidate valid iff t_vld=1, sign=0, exponent!=8'hFF (rejects NaN/inf), and t > T_MIN.
  - Comparison is unsigned integer compare of the bit patterns, which is legal for positive fp32.
  - -0.0 and denormals below T_MIN are rejected.
- States:
  - EMPTY: no valid candidate yet for the current ray. A valid candidate loads best_t/best_id and moves to HOLD.
  - HOLD: a best candidate is held. A valid candidate with t strictly less than best_t replaces it. Ties keep the earlier candidate.
- Last candidate:
  - On t_vld & t_last, the last candidate is included in the comparison combinationally.
  - The output registers load the final result; hit_vld=1 on the next cycle; state returns to EMPTY.
  - Latency is 1 cycle from the last candidate to hit_vld.
- Single-candidate ray (t_vld & t_last while EMPTY) is legal. Its result is hit=1 if the candidate is valid, else hit=0.
- Back-to-back rays: the first candidate of the next ray may arrive the cycle right after t_last. It must be evaluated against a fresh EMPTY state, not the previous best.
- Outputs hit, hit_t and hit_prim_id hold their values until the next result. hit_vld is low otherwise.
- Candidate counter:
  - Increments on every t_vld and clears after t_last.
  - On a t_vld with count==MAX_PRIMS (count width $clog2(MAX_PRIMS+1)), overflow sets and stays set until reset.
  - Reduction continues unaffected; the counter saturates.
- t_vld=0 cycles inside a ray are bubbles: state is held.

Optional Feature:
- Macro CLOSEST_HIT_STATS_EN.
- When defined, adds outputs stat_rays (32), stat_hits (32) and stat_cands (32).
- These are free-running counters of emitted results, results with hit=1, and accepted valid candidates. They wrap modulo 2^32 and reset to 0.
- When undefined, the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/defines gains:
  - FP32_POS_INF (32'h7F800000)
  - hit_rec_t struct {hit, t, prim_id}
  - fp32_is_finite_pos helper function
- fp32_t is reused as-is.
- One natural sub-module: fp32_pos_lt, a combinational strict less-than on positive finite fp32 bit patterns, reusable by later BVH slab-test stages.

Test Plan:
- Ray of 3: t = 3F800000 (1.0, id 5), 3F000000 (0.5, id 7), 40000000 (2.0, id 9, last) -> one cycle later: hit_vld=1, hit=1, hit_t=3F000000, hit_prim_id=7.
- Ray of 3: BF800000 (-1.0), 7FC00000 (NaN), 3A000000 (<T_MIN, last) -> hit=0, hit_t=7F800000, hit_prim_id=0.
- Tie: 3F800000 id 2, then 3F800000 id 4 (last) -> hit_prim_id=2.
- Back-to-back: single-candidate ray 3F000000 id 1 (last), next cycle ray 40000000 id 3 (last) -> consecutive pulses reporting 3F000000/1 then 40000000/3; second result not contaminated by the first.
- Reset mid-ray: two valid candidates, then rst_n low for 1 cycle, then 40400000 id 6 (last) -> hit_t=40400000, hit_prim_id=6; no pulse for the aborted ray.
- MAX_PRIMS=4 build: 5 candidates without t_last, then 1 with t_last -> overflow=1 from the 5th candidate onward and after. Result is still the correct minimum.

Source files
------------

// File: rtl/closest_hit_tracker_pkg.sv
// Shared types and helpers for the closest-hit reduction stage.
package closest_hit_tracker_pkg;

    typedef logic [31:0] fp32_t;

    localparam fp32_t FP32_POS_INF = 32'h7F80_0000;

    // Widest primitive index a hit record can carry.
    localparam int unsigned PRIM_ID_W_MAX = 16;

    typedef struct packed {
        logic                     hit;
        fp32_t                    t;
        logic [PRIM_ID_W_MAX-1:0] prim_id;
    } hit_rec_t;

    function automatic logic fp32_is_finite_pos(input fp32_t x);
        return (x[31] == 1'b0) && (x[30:23] != 8'hFF);
    endfunction

endpackage

// File: rtl/fp32_pos_lt.sv
// Strict less-than on positive finite fp32 bit patterns; the ordering of such
// patterns matches their unsigned integer ordering.
module fp32_pos_lt
    import closest_hit_tracker_pkg::*;
(
    input  fp32_t a,
    input  fp32_t b,
    output logic  lt
);

    assign lt = (a < b);

endmodule

// File: rtl/closest_hit_tracker.sv
// Reduces a stream of per-primitive fp32 ray distances to the nearest valid hit.
// Optional statistics counters are enabled by defining CLOSEST_HIT_STATS_EN.
module closest_hit_tracker
    import closest_hit_tracker_pkg::*;
#(
    parameter int unsigned PRIM_ID_W = 16,
    parameter fp32_t       T_MIN     = 32'h3A83_126F,
    parameter int unsigned MAX_PRIMS = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 t_vld,
    input  fp32_t                t,
    input  logic [PRIM_ID_W-1:0] t_prim_id,
    input  logic                 t_last,
    output logic                 hit_vld,
    output logic                 hit,
    output fp32_t                hit_t,
    output logic [PRIM_ID_W-1:0] hit_prim_id,
    output logic                 overflow
`ifdef CLOSEST_HIT_STATS_EN
    ,
    output logic [31:0]          stat_rays,
    output logic [31:0]          stat_hits,
    output logic [31:0]          stat_cands
`endif
);

    localparam int unsigned CNT_W = $clog2(MAX_PRIMS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PRIMS);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    logic [0:0]           state_q, state_d;
    fp32_t                best_t_q, best_t_d;
    logic [PRIM_ID_W-1:0] best_id_q, best_id_d;
    hit_rec_t             res_q, res_d;
    logic                 hit_vld_q, hit_vld_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 overflow_q, overflow_d;

    logic                 cand_ok;
    logic                 cand_lt;
    logic                 take;
    logic                 nb_valid;
    fp32_t                nb_t;
    logic [PRIM_ID_W-1:0] nb_id;
    hit_rec_t             final_rec;

    fp32_pos_lt u_lt (
        .a  (t),
        .b  (best_t_q),
        .lt (cand_lt)
    );

    // Merged view of the held best and the current candidate; on t_last this is the result.
    always_comb begin
        cand_ok  = t_vld && fp32_is_finite_pos(t) && (t > T_MIN);
        take     = cand_ok && ((state_q == EMPTY) || cand_lt);
        nb_valid = (state_q == HOLD) || cand_ok;
        nb_t     = take ? t : best_t_q;
        nb_id    = take ? t_prim_id : best_id_q;

        final_rec.hit     = nb_valid;
        final_rec.t       = nb_valid ? nb_t : FP32_POS_INF;
        final_rec.prim_id = nb_valid ? PRIM_ID_W_MAX'(nb_id) : '0;
    end

    always_comb begin
        state_d    = state_q;
        best_t_d   = best_t_q;
        best_id_d  = best_id_q;
        res_d      = res_q;
        hit_vld_d  = 1'b0;
        cnt_d      = cnt_q;
        overflow_d = overflow_q;

        if (t_vld) begin
            if (t_last) begin
                res_d     = final_rec;
                hit_vld_d = 1'b1;
                state_d   = EMPTY;
                best_t_d  = FP32_POS_INF;
                best_id_d = '0;
                cnt_d     = '0;
            end else begin
                state_d   = nb_valid ? HOLD : EMPTY;
                best_t_d  = nb_t;
                best_id_d = nb_id;
                cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            end
            if (cnt_q == CNT_MAX) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            best_t_q   <= FP32_POS_INF;
            best_id_q  <= '0;
            res_q      <= '{hit: 1'b0, t: FP32_POS_INF, prim_id: '0};
            hit_vld_q  <= 1'b0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            best_t_q   <= best_t_d;
            best_id_q  <= best_id_d;
            res_q      <= res_d;
            hit_vld_q  <= hit_vld_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
        end
    end

    assign hit_vld     = hit_vld_q;
    assign hit         = res_q.hit;
    assign hit_t       = res_q.t;
    assign hit_prim_id = res_q.prim_id[PRIM_ID_W-1:0];
    assign overflow    = overflow_q;

`ifdef CLOSEST_HIT_STATS_EN
    logic [31:0] rays_q, hits_q, cands_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rays_q  <= '0;
            hits_q  <= '0;
            cands_q <= '0;
        end else begin
            if (t_vld && t_last) begin
                rays_q <= rays_q + 32'd1;
                if (final_rec.hit) begin
                    hits_q <= hits_q + 32'd1;
                end
            end
            if (cand_ok) begin
                cands_q <= cands_q + 32'd1;
            end
        end
    end

    assign stat_rays  = rays_q;
    assign stat_hits  = hits_q;
    assign stat_cands = cands_q;
`endif

endmodule
